fpga_link_rx: RTL
=================

Name: fpga_link_rx

Overview:
Receive endpoint of the inter-FPGA 32-bit parallel link driven by the sender block on the far FPGA. It runs the four-phase req/ack handshake and advertises ready. Accepted words are buffered in a small FIFO for a local consumer. A built-in pattern checker compares incoming data against the sender's decrementing test sequence and drives a pass indication for the board LED.

Parameters:
RECEIVE_COUNT, 100, number of words expected before a transfer is complete
FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2
SYNC_STAGES, 2, flop stages on the req_in and send_done pins; minimum 2
SEED, 32'hFFFFFFFF, first expected data word

Ports:
clk  input  1  single system clock
rst  input  1  asynchronous, active-low reset
data_in  input  32  link data from sender; stable while req_in is high
req_in  input  1  sender request, asynchronous to local logic
send_done  input  1  sender has finished its burst, level, asynchronous
rdy_out  output  1  receiver able to accept a word
ack_out  output  1  four-phase acknowledge to sender
data_out  output  32  FIFO head word
data_valid  output  1  FIFO non-empty; data_out is valid
data_ready  input  1  consumer pops the head when data_valid && data_ready
word_count  output  16  words accepted since reset, saturating at 16'hFFFF
error  output  1  sticky; pattern mismatch or overrun
done  output  1  transfer finished
led  output  1  pass indication

Behaviour:
- Reset (rst low, async) state:
  - rdy_out, ack_out, data_valid, error, done and led = 0.
  - word_count = 0; FIFO empty; expected = SEED; FSM = IDLE.
  - Asserting reset mid-handshake drops ack_out immediately.
- req_in and send_done each pass through SYNC_STAGES flops; the outputs are req_s and sd_s.
- data_in is sampled in the cycle req_s is first seen high. The sender holds data from before req rises until ack is seen.
- rdy_out = (state == WAIT_REQ) && !fifo_full. It is registered and updates one cycle after the FIFO state changes.
- FSM states and transitions:
  - IDLE: go to WAIT_REQ on the first cycle after reset.
  - WAIT_REQ:
    - If req_s && !fifo_full: push data_in, increment word_count, run the checker, set ack_out=1, go to ACK.
    - If req_s && fifo_full: hold with no ack; the sender stalls.
    - If sd_s && !req_s: go to DONE.
  - ACK: hold ack_out=1 until req_s==0, then clear ack_out and go to WAIT_REQ.
  - DONE: done=1, rdy_out=0, ack_out=0. Further req_s is ignored and no ack is given. Leave DONE only by reset.
- Handshake latency: ack_out rises SYNC_STAGES+1 cycles after req_in rises and falls SYNC_STAGES+1 cycles after req_in falls.
- FIFO rules:
  - Push and pop in the same cycle are both legal, including when full. With rdy gating, a push never occurs when full.
  - A pop when empty is ignored.
  - data_out holds its last value when empty.
- Checker:
  - On each push, compare data_in to expected; on mismatch set error.
  - Then expected <= expected - 1, with modulo-2^32 wrap (32'h00000000 -> 32'hFFFFFFFF).
- Overrun: a word accepted when word_count >= RECEIVE_COUNT sets error. The word is still pushed and acked.
- Short transfer: sd_s arriving before RECEIVE_COUNT words still enters DONE; led stays 0.
- led is registered: led = done && (word_count == RECEIVE_COUNT) && !error.
- Simultaneous req_s and sd_s in WAIT_REQ: the request takes priority. DONE is entered only after the handshake completes and req_s is low.

Optional Feature:
FPGA_LINK_RX_CHECK_EN
- Defined: the pattern checker and mismatch error are present, as above.
- Undefined: no expected register or comparator. error reflects overrun only, and led = done && (word_count == RECEIVE_COUNT) && !error.

Decomposition:
- Shared package holds:
  - link data width constant LINK_DW = 32;
  - FSM state enum {IDLE, WAIT_REQ, ACK, DONE};
  - default SEED constant;
  - word_count width constant.
- One natural sub-module: fpga_link_rx_fifo. It is a synchronous FIFO parameterised by width and depth, with full, empty, push and pop.
- The synchronizer is an inline generate loop; it is not a separate module.

Test Plan:
- Nominal burst: 100 words 32'hFFFFFFFF downward, four-phase handshake, then send_done -> word_count=100, error=0, done=1, led=1, and the consumer pops all 100 in order.
- Corrupt word: 5th word sent as 32'h12345678 -> error=1 sticky, led=0 after done, word_count=100.
- Backpressure: data_ready=0 throughout, 6 words offered with FIFO_DEPTH=4 -> rdy_out=0 after 4 pushes, ack withheld on word 5. Raising data_ready drains the FIFO and the remaining words complete in order.
- Short and overrun: send_done after 60 words -> done=1, led=0, error=0. A separate run with 101 words -> error=1.
- Reset mid-handshake: drop rst while ack_out=1 -> ack_out=0 in the same cycle. After release, a fresh 100-word burst passes with led=1.
- Wrap: SEED=32'h00000001, 3 words 1,0,FFFFFFFF -> error=0.

Source files
------------

// File: rtl/fpga_link_rx_pkg.sv
// Shared constants and state encoding for the inter-FPGA link receiver.
package fpga_link_rx_pkg;

    localparam int LINK_DW = 32;
    localparam int WC_W    = 16;
    localparam logic [LINK_DW-1:0] DEFAULT_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        ACK      = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/fpga_link_rx_fifo.sv
// Synchronous FIFO with power-of-two depth; data_out holds the last popped word when empty.
module fpga_link_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fpga_link_rx.sv
// Receive endpoint of the inter-FPGA req/ack link: synchronizers, handshake FSM, output FIFO, pattern checker.
// Define FPGA_LINK_RX_CHECK_EN to include the decrementing-pattern checker; otherwise error reports overrun only.
module fpga_link_rx
    import fpga_link_rx_pkg::*;
#(
    parameter int                 RECEIVE_COUNT = 100,
    parameter int                 FIFO_DEPTH    = 4,
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [LINK_DW-1:0] SEED          = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINK_DW-1:0] data_in,
    input  logic               req_in,
    input  logic               send_done,
    output logic               rdy_out,
    output logic               ack_out,
    output logic [LINK_DW-1:0] data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic [WC_W-1:0]    word_count,
    output logic               error,
    output logic               done,
    output logic               led,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_WAIT_REQ = WAIT_REQ;
    localparam logic [1:0] S_ACK      = ACK;
    localparam logic [1:0] S_DONE     = DONE;

    localparam logic [WC_W-1:0] RC_W = WC_W'(RECEIVE_COUNT);

    logic [1:0] state;
    logic       req_s;
    logic       sd_s;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       mismatch;
    logic       overrun;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic req_q;
        logic sd_q;
        if (g == 0) begin : g_first
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    req_q <= 1'b0;
                    sd_q  <= 1'b0;
                end else begin
                    req_q <= req_in;
                    sd_q  <= send_done;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    req_q <= 1'b0;
                    sd_q  <= 1'b0;
                end else begin
                    req_q <= g_sync[g-1].req_q;
                    sd_q  <= g_sync[g-1].sd_q;
                end
            end
        end
    end

    assign req_s = g_sync[SYNC_STAGES-1].req_q;
    assign sd_s  = g_sync[SYNC_STAGES-1].sd_q;

    // Handshake: a word is taken on the first WAIT_REQ cycle with req_s high and room in
    // the FIFO; ack_out then stays high until req_s drops, and a full FIFO withholds ack.
    assign push      = (state == S_WAIT_REQ) && req_s && !fifo_full;
    assign overrun   = push && (word_count >= RC_W);
    assign state_dbg = state;

`ifdef FPGA_LINK_RX_CHECK_EN
    logic [LINK_DW-1:0] expected;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected <= SEED;
        end else if (push) begin
            expected <= expected - 32'd1;
        end
    end

    assign mismatch = push && (data_in != expected);
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ack_out    <= 1'b0;
            rdy_out    <= 1'b0;
            done       <= 1'b0;
            led        <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            rdy_out <= (state == S_WAIT_REQ) && !fifo_full;
            led     <= done && (word_count == RC_W) && !error;
            if (mismatch || overrun) begin
                error <= 1'b1;
            end
            case (state)
                S_IDLE: state <= S_WAIT_REQ;
                S_WAIT_REQ: begin
                    if (req_s) begin
                        if (!fifo_full) begin
                            ack_out <= 1'b1;
                            state   <= S_ACK;
                            if (word_count != '1) begin
                                word_count <= word_count + 1'b1;
                            end
                        end
                    end else if (sd_s) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ACK: begin
                    if (!req_s) begin
                        ack_out <= 1'b0;
                        state   <= S_WAIT_REQ;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    ack_out <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fpga_link_rx_fifo #(
        .WIDTH (LINK_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (data_ready),
        .pop_data  (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_valid = !fifo_empty;

endmodule
